regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Shares the register file's single write port (write/writenum/data_in, committed at rising clk) and single combinational read port (readnum -> data_out) between two requesters each.
- Write requesters: W0 = ALU writeback, W1 = memory-load writeback.
- Read requesters: R0 = operand fetch, R1 = debug/status reader.
- Round-robin per port, valid/ready handshakes, registered read return, same-cycle write-to-read bypass.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register index width (8 registers).

Ports:
- clk  in  1  rising-edge clock, shared with the register file
- reset  in  1  synchronous, active-high
- w0_valid, w1_valid  in  1 each  write request
- w0_num, w1_num  in  ADDR_W each  target register
- w0_data, w1_data  in  DATA_W each  write data
- w0_ready, w1_ready  out  1 each  grant; the write commits at this cycle's rising edge
- r0_valid, r1_valid  in  1 each  read request
- r0_num, r1_num  in  ADDR_W each  source register
- r0_ready, r1_ready  out  1 each  read grant (combinational)
- r0_rvalid, r1_rvalid  out  1 each  read data valid, one cycle after grant
- r0_rdata, r1_rdata  out  DATA_W each  registered read data
- rf_write  out  1  to regfile write
- rf_writenum  out  ADDR_W  to regfile writenum
- rf_data_in  out  DATA_W  to regfile data_in
- rf_readnum  out  ADDR_W  to regfile readnum
- rf_data_out  in  DATA_W  from regfile data_out

Behaviour:
- Handshake: a transfer occurs in a cycle where valid && ready. The requester holds num and data stable until ready. The arbiter never asserts ready without valid.
- Ready outputs are combinational from the valid inputs and the priority pointers.
- Write arbitration:
  - wr_ptr (1 bit) names the preferred requester. Reset value 0 (W0 preferred).
  - One requester valid: it is granted.
  - Both valid: the wr_ptr requester is granted.
  - After any grant, wr_ptr <= !granted index.
- Write drive:
  - rf_write = granted && !reset.
  - rf_writenum and rf_data_in come from the granted requester. When nothing is granted they are 0.
  - The register file commits at the same rising edge, so write latency is 0 cycles after the grant.
- Read arbitration: independent rd_ptr, same rules as writes. Reset value 0.
  - rf_readnum = granted rN_num. When nothing is granted it is 0.
- Read return:
  - At the rising edge ending the grant cycle: rN_rdata <= rf_data_out and rN_rvalid <= 1 for the granted N.
  - The non-granted rvalid <= 0. rvalid is a single-cycle pulse per grant.
  - rdata holds its last value when rvalid is 0.
- Bypass:
  - Trigger: in the same cycle a write is granted and a read is granted with rf_writenum == rf_readnum.
  - Then the captured rdata = rf_data_in, not rf_data_out.
  - Effect: a same-cycle read returns the newly written value.
- Back-to-back grants: a requester holding valid high is granted every cycle only when the other requester is idle. Under contention, grants alternate strictly (W0,W1,W0,...).
- Reset (synchronous, takes precedence over everything):
  - wr_ptr=0, rd_ptr=0.
  - r0_rvalid=r1_rvalid=0, r0_rdata=r1_rdata=0.
  - All ready outputs are 0 and rf_write=0 in any cycle where reset=1. No register-file write occurs.
  - A request pending when reset asserts is dropped; the requester must re-present it after reset.
  - A read granted in the cycle before reset produces no rvalid.
- No internal queues. Starvation is impossible: worst-case wait is 1 cycle per port.

Decomposition:
- Shared package (riscm_pkg): DATA_W and ADDR_W constants; requester index encoding (REQ0=0, REQ1=1).
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter.
  - Inputs: clk, reset, req[1:0].
  - Outputs: gnt[1:0] (one-hot/zero, combinational) and the pointer update.
  - Instantiated twice, once for the write port and once for the read port.
- Capture, bypass and output muxing stay in the top module.

Test Plan:
1. Reset held 2 cycles with w0_valid=1, w0_num=3, w0_data=16'h00AA -> w0_ready=0, rf_write=0 throughout. After release, reading R3 returns the prior value (0 after a fresh regfile init).
2. W0 writes R1=16'd1 alone, then R0 reads R1 next cycle -> w0_ready=1 for 1 cycle; r0_rvalid pulses 1 cycle after grant with r0_rdata=16'd1.
3. W0 (R2=16'd2) and W1 (R3=16'd3) valid together from reset -> grant order W0 then W1. Subsequent reads return R2=2 and R3=3. wr_ptr alternates under sustained contention: 4 cycles give W0,W1,W0,W1.
4. Same cycle: W1 writes R4=16'd17 and R0 reads R4 (old value 16'd4) -> r0_rdata=16'd17 (bypass). The next read of R4 also returns 17.
5. R0 and R1 both request continuously (R1 -> R4, R0 -> R1) -> alternating single-cycle r0_rvalid/r1_rvalid pulses, each with correct data. Neither rvalid is high 2 consecutive cycles.
6. Write with valid=0 but data/num toggling (num=4, data=16'h0040) -> rf_write=0. R4 still reads 16'd17.

Source files
------------

// File: rtl/riscm_pkg.sv
// Shared constants and requester encoding for the register-file port arbiter.
// The two-way arbiters and the top-level capture logic import this package.
package riscm_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_t;

    // One-hot grant vector naming a single requester.
    function automatic logic [1:0] req_onehot(input req_idx_t idx);
        return (idx == REQ1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant from req and the preference pointer.
// After any grant the pointer moves to the other requester; reset blocks all grants.
module rr_arb2
    import riscm_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output req_idx_t ptr
);

    req_idx_t ptr_q, ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = req_onehot(ptr_q);
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = REQ1;
        end else if (gnt[1]) begin
            ptr_d = REQ0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file's single write port and single read port between two requesters
// each, with registered read return and same-cycle write-to-read bypass.
module regfile_port_arbiter
    import riscm_pkg::*;
#(
    parameter int unsigned DATA_W = riscm_pkg::DATA_W,
    parameter int unsigned ADDR_W = riscm_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              w0_valid,
    input  logic [ADDR_W-1:0] w0_num,
    input  logic [DATA_W-1:0] w0_data,
    output logic              w0_ready,
    input  logic              w1_valid,
    input  logic [ADDR_W-1:0] w1_num,
    input  logic [DATA_W-1:0] w1_data,
    output logic              w1_ready,

    input  logic              r0_valid,
    input  logic [ADDR_W-1:0] r0_num,
    output logic              r0_ready,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r1_num,
    output logic              r1_ready,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,

    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_writenum,
    output logic [DATA_W-1:0] rf_data_in,
    output logic [ADDR_W-1:0] rf_readnum,
    input  logic [DATA_W-1:0] rf_data_out
);

    logic [1:0]        wr_gnt;
    logic [1:0]        rd_gnt;
    req_idx_t          wr_ptr;
    req_idx_t          rd_ptr;
    logic              bypass;
    logic [DATA_W-1:0] rd_capture;

    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({w1_valid, w0_valid}),
        .gnt   (wr_gnt),
        .ptr   (wr_ptr)
    );

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({r1_valid, r0_valid}),
        .gnt   (rd_gnt),
        .ptr   (rd_ptr)
    );

    assign w0_ready = wr_gnt[0];
    assign w1_ready = wr_gnt[1];
    assign r0_ready = rd_gnt[0];
    assign r1_ready = rd_gnt[1];

    // Grants are already masked by reset inside the arbiters.
    assign rf_write = |wr_gnt;

    always_comb begin
        rf_writenum = '0;
        rf_data_in  = '0;
        unique case (wr_gnt)
            2'b01: begin
                rf_writenum = w0_num;
                rf_data_in  = w0_data;
            end
            2'b10: begin
                rf_writenum = w1_num;
                rf_data_in  = w1_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        rf_readnum = '0;
        unique case (rd_gnt)
            2'b01:   rf_readnum = r0_num;
            2'b10:   rf_readnum = r1_num;
            default: ;
        endcase
    end

    // The register file only commits at the edge, so a same-cycle read would see stale data.
    assign bypass     = rf_write && (|rd_gnt) && (rf_writenum == rf_readnum);
    assign rd_capture = bypass ? rf_data_in : rf_data_out;

    always_comb begin
        rvalid_d = rd_gnt;
        rdata0_d = rd_gnt[0] ? rd_capture : rdata0_q;
        rdata1_d = rd_gnt[1] ? rd_capture : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // A read granted just before reset must not surface as a valid pulse during reset.
    assign r0_rvalid = rvalid_q[0] && !reset;
    assign r1_rvalid = rvalid_q[1] && !reset;
    assign r0_rdata  = rdata0_q;
    assign r1_rdata  = rdata1_q;

    // Pointers are internal state; exposed only for visibility in simulation.
    logic unused_ptrs;
    assign unused_ptrs = ^{wr_ptr, rd_ptr};

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed plus randomized bench for regfile_port_arbiter with an attached behavioural
// register file and a transaction-level fairness model.
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        w0_valid, w1_valid, r0_valid, r1_valid;
    logic [2:0]  w0_num, w1_num, r0_num, r1_num;
    logic [15:0] w0_data, w1_data;
    logic        w0_ready, w1_ready, r0_ready, r1_ready;
    logic        r0_rvalid, r1_rvalid;
    logic [15:0] r0_rdata, r1_rdata;
    logic        rf_write;
    logic [2:0]  rf_writenum, rf_readnum;
    logic [15:0] rf_data_in, rf_data_out;

    always #5 clk = ~clk;

    regfile_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .w0_valid    (w0_valid),
        .w0_num      (w0_num),
        .w0_data     (w0_data),
        .w0_ready    (w0_ready),
        .w1_valid    (w1_valid),
        .w1_num      (w1_num),
        .w1_data     (w1_data),
        .w1_ready    (w1_ready),
        .r0_valid    (r0_valid),
        .r0_num      (r0_num),
        .r0_ready    (r0_ready),
        .r0_rvalid   (r0_rvalid),
        .r0_rdata    (r0_rdata),
        .r1_valid    (r1_valid),
        .r1_num      (r1_num),
        .r1_ready    (r1_ready),
        .r1_rvalid   (r1_rvalid),
        .r1_rdata    (r1_rdata),
        .rf_write    (rf_write),
        .rf_writenum (rf_writenum),
        .rf_data_in  (rf_data_in),
        .rf_readnum  (rf_readnum),
        .rf_data_out (rf_data_out)
    );

    // Register file attached to the arbiter: combinational read, write at the rising edge.
    logic [15:0] rf_mem [8];
    always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
    assign rf_data_out = rf_mem[rf_readnum];

    // Reference model state: who is owed the next contended grant, and the architectural regs.
    int          errors = 0;
    int          checks = 0;
    int          w_turn = 0;
    int          r_turn = 0;
    logic [15:0] m_regs [8];
    logic        e_rv [2];
    logic [15:0] e_rd [2];
    logic        e_known = 1'b0;
    int          last_ww, last_rw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic v0, input logic v1, input int turn);
        if (v0 && v1) return turn;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic cycle(input logic rst_v,
                         input logic a_v, input logic [2:0] a_n, input logic [15:0] a_d,
                         input logic b_v, input logic [2:0] b_n, input logic [15:0] b_d,
                         input logic c_v, input logic [2:0] c_n,
                         input logic d_v, input logic [2:0] d_n);
        int          ww, rw;
        logic [2:0]  wn, rn;
        logic [15:0] wd, pred;
        reset = rst_v;
        w0_valid = a_v; w0_num = a_n; w0_data = a_d;
        w1_valid = b_v; w1_num = b_n; w1_data = b_d;
        r0_valid = c_v; r0_num = c_n;
        r1_valid = d_v; r1_num = d_n;
        ww = rst_v ? -1 : pick(a_v, b_v, w_turn);
        rw = rst_v ? -1 : pick(c_v, d_v, r_turn);
        wn = (ww == 0) ? a_n : (ww == 1) ? b_n : 3'd0;
        wd = (ww == 0) ? a_d : (ww == 1) ? b_d : 16'd0;
        rn = (rw == 0) ? c_n : (rw == 1) ? d_n : 3'd0;
        // A read of the register being written this cycle returns the new value.
        pred = (ww >= 0 && rw >= 0 && wn == rn) ? wd : m_regs[rn];
        #1;
        chk("w0_ready", 32'(w0_ready), 32'(ww == 0));
        chk("w1_ready", 32'(w1_ready), 32'(ww == 1));
        chk("rf_write", 32'(rf_write), 32'(ww >= 0));
        chk("rf_writenum", 32'(rf_writenum), 32'(wn));
        chk("rf_data_in", 32'(rf_data_in), 32'(wd));
        chk("r0_ready", 32'(r0_ready), 32'(rw == 0));
        chk("r1_ready", 32'(r1_ready), 32'(rw == 1));
        chk("rf_readnum", 32'(rf_readnum), 32'(rn));
        chk("r0_rvalid", 32'(r0_rvalid), 32'(e_rv[0] && !rst_v));
        chk("r1_rvalid", 32'(r1_rvalid), 32'(e_rv[1] && !rst_v));
        if (e_known) begin
            chk("r0_rdata", 32'(r0_rdata), 32'(e_rd[0]));
            chk("r1_rdata", 32'(r1_rdata), 32'(e_rd[1]));
        end
        @(posedge clk);
        if (rst_v) begin
            w_turn = 0; r_turn = 0;
            e_rv[0] = 1'b0; e_rv[1] = 1'b0;
            e_rd[0] = 16'd0; e_rd[1] = 16'd0;
            e_known = 1'b1;
        end else begin
            e_rv[0] = (rw == 0);
            e_rv[1] = (rw == 1);
            if (rw >= 0) begin
                e_rd[rw] = pred;
                r_turn = 1 - rw;
            end
            if (ww >= 0) begin
                m_regs[wn] = wd;
                w_turn = 1 - ww;
            end
        end
        last_ww = ww;
        last_rw = rw;
        #1;
    endtask

    logic        q_w0v, q_w1v, q_r0v, q_r1v, q_rst;
    logic [2:0]  q_w0n, q_w1n, q_r0n, q_r1n;
    logic [15:0] q_w0d, q_w1d;

    initial begin
        for (int i = 0; i < 8; i++) begin
            rf_mem[i] = 16'd0;
            m_regs[i] = 16'd0;
        end
        e_rv[0] = 1'b0; e_rv[1] = 1'b0;
        e_rd[0] = 16'd0; e_rd[1] = 16'd0;

        // Reset with a pending write: dropped, R3 still reads 0.
        cycle(1, 1, 3'd3, 16'h00AA, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 3'd3, 16'h00AA, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 3'd3, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r3_after_reset", 32'(r0_rdata), 32'h0);

        // Lone write then read-back.
        cycle(0, 1, 3'd1, 16'd1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 3'd1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r1_readback", 32'(r0_rdata), 32'd1);

        // Contention from reset: W0 first, then W1; sustained contention alternates.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 3'd2, 16'd2, 1, 3'd3, 16'd3, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 3'd3, 16'd3, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 3'd2, 1, 3'd3);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd3);
        cycle(0, 1, 3'd5, 16'd5, 1, 3'd6, 16'd6, 0, 0, 0, 0);
        cycle(0, 1, 3'd5, 16'h55, 1, 3'd6, 16'd6, 0, 0, 0, 0);
        cycle(0, 1, 3'd5, 16'h55, 1, 3'd6, 16'h66, 0, 0, 0, 0);
        cycle(0, 1, 3'd7, 16'd7, 1, 3'd6, 16'h66, 0, 0, 0, 0);
        chk("contention_last_w1", 32'(last_ww), 32'd1);
        cycle(0, 1, 3'd4, 16'd4, 0, 0, 0, 0, 0, 0, 0);

        // Bypass: W1 writes R4=17 while R0 reads R4.
        cycle(0, 0, 0, 0, 1, 3'd4, 16'd17, 1, 3'd4, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 3'd4, 0, 0);
        chk("bypass_r4", 32'(r0_rdata), 32'd17);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r4_after_bypass", 32'(r0_rdata), 32'd17);

        // Both readers continuously: alternating single-cycle pulses.
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 3'd1, 1, 3'd4);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Invalid write with toggling fields must not reach the register file.
        cycle(0, 0, 3'd4, 16'h0040, 0, 3'd4, 16'h0040, 0, 0, 0, 0);
        cycle(0, 0, 3'd2, 16'h1234, 0, 0, 0, 1, 3'd4, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r4_unchanged", 32'(r0_rdata), 32'd17);

        // Random traffic: requesters hold fields until granted; reset drops everything.
        q_w0v = 0; q_w1v = 0; q_r0v = 0; q_r1v = 0;
        q_w0n = 0; q_w1n = 0; q_r0n = 0; q_r1n = 0; q_w0d = 0; q_w1d = 0;
        for (int i = 0; i < 400; i++) begin
            q_rst = ($urandom_range(0, 39) == 0);
            cycle(q_rst, q_w0v, q_w0n, q_w0d, q_w1v, q_w1n, q_w1d, q_r0v, q_r0n, q_r1v, q_r1n);
            if (q_rst || last_ww == 0 || !q_w0v) begin
                q_w0v = 1'($urandom_range(0, 1));
                q_w0n = 3'($urandom_range(0, 7));
                q_w0d = 16'($urandom);
            end
            if (q_rst || last_ww == 1 || !q_w1v) begin
                q_w1v = 1'($urandom_range(0, 1));
                q_w1n = 3'($urandom_range(0, 7));
                q_w1d = 16'($urandom);
            end
            if (q_rst || last_rw == 0 || !q_r0v) begin
                q_r0v = 1'($urandom_range(0, 1));
                q_r0n = 3'($urandom_range(0, 7));
            end
            if (q_rst || last_rw == 1 || !q_r1v) begin
                q_r1v = 1'($urandom_range(0, 1));
                q_r1n = 3'($urandom_range(0, 7));
            end
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
